// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, unsigned binary to packed BCD.
// One conversion per accepted start, one shift per clock.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   conversion request, sampled only in IDLE
//   bin_in   in   BIN_W-bit unsigned operand, captured on accepted start
//   busy     out  high while shifting
//   done     out  one-cycle pulse when bcd_out/ovf are updated
//   bcd_out  out  4*DIGITS-bit packed BCD, digit 0 = units
//   ovf      out  value exceeded 10^DIGITS-1, bcd_out truncated
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned TOT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [TOT_W-1:0]   w_cat;
    logic [TOT_W-1:0]   w_cat_sh;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BIN_W-1:0]   w_shift_next;
    logic               w_acc_next;
    logic               w_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add-3 on every digit >= 5, all digits in parallel, ahead of the shift
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4];
            end
        end
    end

    // Bit falling off the top digit means the value no longer fits
    assign w_cat        = {w_adj, r_shift};
    assign w_cat_sh     = w_cat << 1;
    assign w_bcd_next   = w_cat_sh[TOT_W-1 -: BCD_W];
    assign w_shift_next = w_cat_sh[BIN_W-1:0];
    assign w_acc_next   = r_acc | w_cat[TOT_W-1];
    assign w_last       = (r_cnt == CNT_LAST);

    // Datapath and registered outputs; done/busy follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bcd     <= '0;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd_out <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_SHIFT);
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= bin_in;
                        r_bcd   <= '0;
                        r_acc   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shift <= w_shift_next;
                    r_bcd   <= w_bcd_next;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd_out <= w_bcd_next;
                        r_ovf     <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd_out;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit instance share
// the same stimulus; results are compared against a divide/modulo decimal model.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy,  done,  ovf;
    logic [11:0] bcd_out;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd_out2;

    int n_pass;
    int n_total;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp3;
        logic [7:0]  exp2;
        logic        exp_ovf2;
    } vec_t;

    // Decimal reference: digit k = (v / 10^k) % 10; overflow when v >= 10^digits
    function automatic logic [11:0] ref_bcd(input int v, input int digits, output logic ovf_o);
        int          p;
        logic [11:0] r;
        p = 1;
        r = '0;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        ovf_o = (v >= p);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Caller is #1 after an edge with DUT idle. Pulses start for one edge, waits
    // for done, returns edge offset of done and the captured outputs, then steps
    // one more edge so a following call is accepted back-to-back.
    task automatic run_conv(input logic [7:0] v, output int lat,
                            output logic [11:0] b3, output logic o3,
                            output logic [7:0] b2, output logic o2,
                            output logic busy_ok, output logic d2_ok, output logic tail_ok);
        bin_in  = v;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        bin_in  = ~v;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!(busy === 1'b1)) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        b3    = bcd_out;
        o3    = ovf;
        b2    = bcd_out2;
        o2    = ovf2;
        d2_ok = (done2 === 1'b1);
        @(posedge clk); #1;
        tail_ok = (done === 1'b0) && (busy === 1'b0) && (done2 === 1'b0);
    endtask

    task automatic conv_and_check(input string tag, input logic [7:0] v,
                                  input logic [11:0] e3, input logic [7:0] e2, input logic eo2);
        int          lat;
        logic [11:0] b3;
        logic [7:0]  b2;
        logic        o3, o2, bok, d2ok, tok;
        run_conv(v, lat, b3, o3, b2, o2, bok, d2ok, tok);
        chk({tag, "_latency"}, 32'(lat), 32'(BIN_W));
        chk({tag, "_bcd3"}, 32'(b3), 32'(e3));
        chk({tag, "_ovf3"}, 32'(o3), 32'(0));
        chk({tag, "_bcd2"}, 32'(b2), 32'(e2));
        chk({tag, "_ovf2"}, 32'(o2), 32'(eo2));
        chk({tag, "_busy"}, 32'(bok), 32'(1));
        chk({tag, "_done2_aligned"}, 32'(d2ok), 32'(1));
        chk({tag, "_done_width"}, 32'(tok), 32'(1));
    endtask

    vec_t vecs[8];

    initial begin
        int          lat, ndone, v;
        logic [11:0] b3, e3;
        logic [7:0]  b2;
        logic        o3, o2, bok, d2ok, tok, eo3, eo2, dig_ok;
        logic [11:0] e2w;

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        bin_in  = '0;

        vecs[0] = '{8'd255, 12'h255, 8'h55, 1'b1};
        vecs[1] = '{8'd0,   12'h000, 8'h00, 1'b0};
        vecs[2] = '{8'd99,  12'h099, 8'h99, 1'b0};
        vecs[3] = '{8'd9,   12'h009, 8'h09, 1'b0};
        vecs[4] = '{8'd10,  12'h010, 8'h10, 1'b0};
        vecs[5] = '{8'd200, 12'h200, 8'h00, 1'b1};
        vecs[6] = '{8'd100, 12'h100, 8'h00, 1'b1};
        vecs[7] = '{8'd77,  12'h077, 8'h77, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_bcd",  32'(bcd_out), 32'(0));
        chk("rst_ovf",  32'(ovf), 32'(0));
        chk("rst_bcd2", 32'(bcd_out2), 32'(0));
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) begin
            conv_and_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp3,
                           vecs[i].exp2, vecs[i].exp_ovf2);
            @(posedge clk); #1;
        end

        // Start held 3 cycles with bin_in changing: one conversion of 123 only
        bin_in = 8'd123;
        start  = 1'b1;
        @(posedge clk); #1;
        bin_in = 8'd45;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start  = 1'b0;
        ndone  = 0;
        b3     = '0;
        for (int c = 0; c < 16; c++) begin
            if (done) begin
                ndone++;
                b3 = bcd_out;
            end
            @(posedge clk); #1;
        end
        chk("held_start_done_count", 32'(ndone), 32'(1));
        chk("held_start_bcd", 32'(b3), 32'(12'h123));
        conv_and_check("after_held", 8'd45, 12'h045, 8'h45, 1'b0);

        // Reset mid-conversion of 200
        bin_in = 8'd200;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_bcd",  32'(bcd_out), 32'(0));
        chk("midrst_ovf",  32'(ovf), 32'(0));
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        chk("midrst_quiet", 32'(ndone), 32'(0));
        conv_and_check("post_rst", 8'd77, 12'h077, 8'h77, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            v   = int'($urandom_range(255, 0));
            e3  = ref_bcd(v, 3, eo3);
            e2w = ref_bcd(v, 2, eo2);
            chk("rand_ref_ovf3", 32'(eo3), 32'(0));
            conv_and_check($sformatf("rand%0d_%0d", i, v), 8'(v), e3, e2w[7:0], eo2);
        end

        // Exhaustive, back-to-back every BIN_W+2 cycles
        for (int x = 0; x < 256; x++) begin
            e3  = ref_bcd(x, 3, eo3);
            e2w = ref_bcd(x, 2, eo2);
            run_conv(8'(x), lat, b3, o3, b2, o2, bok, d2ok, tok);
            dig_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (b3[4*k +: 4] > 4'd9) dig_ok = 1'b0;
            end
            chk($sformatf("exh%0d_bcd3", x), 32'(b3), 32'(e3));
            chk($sformatf("exh%0d_digits", x), 32'(dig_ok), 32'(1));
            chk($sformatf("exh%0d_bcd2", x), 32'({o2, b2}), 32'({eo2, e2w[7:0]}));
            chk($sformatf("exh%0d_lat", x), 32'(lat), 32'(BIN_W));
            chk($sformatf("exh%0d_hs", x), 32'({bok, d2ok, tok}), 32'(3'b111));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
